nanorv32_datamem_resp: RTL and testbench

Responder for the nanorv32 data memory interface: the memory-side end of the cpu_datamem_* / datamem_cpu_* req/ack handshake.
- Accepts one request at a time and inserts a programmable number of wait states.
- Services reads and byte-lane writes against an internal word-organised RAM, then acks.
- Sits between the CPU data port and the on-chip data RAM in the SoC top.

---
 rtl/nanorv32_datamem_resp_if.sv | 48 ++++
 rtl/nanorv32_datamem_resp.sv | 212 +++++++++++++++++++++
 tb/tb_nanorv32_datamem_resp.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nanorv32_datamem_resp_if.sv
// nanorv32 data memory bus: CPU-side request/ack handshake.
//   master : CPU (drives cpu_datamem_*, samples datamem_cpu_*)
//   slave  : memory responder (samples cpu_datamem_*, drives datamem_cpu_*)
// Signals:
//   cpu_datamem_addr    byte address, bits [1:0] ignored by the responder
//   cpu_datamem_wdata   write data, lane k = bits [8k+7:8k]
//   cpu_datamem_bytesel lane enables; 4'b0000 = read, nonzero = write
//   cpu_datamem_req     request, held by the CPU until ack is seen
//   datamem_cpu_rdata   read data, valid in the ack cycle of a read
//   datamem_cpu_ack     single-cycle completion pulse
//   datamem_cpu_err     out-of-range access flag (only with
//                       NANORV32_DATAMEM_RESP_ERR_EN defined)
interface nanorv32_datamem_resp_if #(
  parameter int unsigned ADDR_MSB = 31,
  parameter int unsigned DATA_MSB = 31
);

  logic [ADDR_MSB:0] cpu_datamem_addr;
  logic [DATA_MSB:0] cpu_datamem_wdata;
  logic [3:0]        cpu_datamem_bytesel;
  logic              cpu_datamem_req;
  logic [DATA_MSB:0] datamem_cpu_rdata;
  logic              datamem_cpu_ack;
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
  logic              datamem_cpu_err;

  modport master (
    output cpu_datamem_addr, cpu_datamem_wdata, cpu_datamem_bytesel, cpu_datamem_req,
    input  datamem_cpu_rdata, datamem_cpu_ack, datamem_cpu_err
  );

  modport slave (
    input  cpu_datamem_addr, cpu_datamem_wdata, cpu_datamem_bytesel, cpu_datamem_req,
    output datamem_cpu_rdata, datamem_cpu_ack, datamem_cpu_err
  );
`else
  modport master (
    output cpu_datamem_addr, cpu_datamem_wdata, cpu_datamem_bytesel, cpu_datamem_req,
    input  datamem_cpu_rdata, datamem_cpu_ack
  );

  modport slave (
    input  cpu_datamem_addr, cpu_datamem_wdata, cpu_datamem_bytesel, cpu_datamem_req,
    output datamem_cpu_rdata, datamem_cpu_ack
  );
`endif

endinterface : nanorv32_datamem_resp_if

// File: rtl/nanorv32_datamem_resp.sv
// nanorv32 data memory responder.
// Accepts one request at a time from the CPU data port, waits WAIT_STATES
// extra cycles, services a read or byte-lane write against an internal
// word-organised RAM and returns a one-cycle ack.
//
// Ports:
//   clk  clock, all logic on the rising edge
//   rst  synchronous active-high reset (RAM contents are not reset)
//   bus  nanorv32_datamem_resp_if.slave (cpu_datamem_* in, datamem_cpu_* out)
//
// Optional feature macro: NANORV32_DATAMEM_RESP_ERR_EN
//   defined   : accesses with word index >= DEPTH (full address) are acked
//               with datamem_cpu_err=1, leave the RAM untouched and read
//               back 32'hDEADBEEF
//   undefined : no err signal, upper address bits alias modulo DEPTH
//
// Timing: accept at edge t, state ACK during the following cycle(s) as
// counted by WAIT_STATES, registered ack high in the cycle after edge
// t+1+WAIT_STATES. The RAM is written / rdata loaded on the edge entering ACK.
module nanorv32_datamem_resp #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_MSB    = 31,
  parameter int unsigned DATA_MSB    = 31
) (
  input logic                     clk,
  input logic                     rst,
  nanorv32_datamem_resp_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW = DATA_MSB + 1;
  localparam int unsigned NB = DW / 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [AW-1:0]   widx_q, widx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]   bsel_q, bsel_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ack_q, ack_d;

  logic [DW-1:0]   mem_q [DEPTH];

  // Payload of the transaction being serviced: straight from the bus on the
  // acceptance edge (needed when WAIT_STATES=0), otherwise the latched copy.
  logic [AW-1:0]   in_idx_c;
  logic [AW-1:0]   sel_idx_c;
  logic [DW-1:0]   sel_wdata_c;
  logic [NB-1:0]   sel_bsel_c;
  logic            enter_ack_c;
  logic            we_c;

  assign in_idx_c = bus.cpu_datamem_addr[AW+1:2];

`ifdef NANORV32_DATAMEM_RESP_ERR_EN
  logic            oor_q, oor_d;
  logic            err_q, err_d;
  logic            in_oor_c;
  logic            sel_oor_c;

  // Any set address bit above the word-index field means index >= DEPTH.
  if (ADDR_MSB > AW + 1) begin : g_oor
    assign in_oor_c = |bus.cpu_datamem_addr[ADDR_MSB:AW+2];
  end else begin : g_no_oor
    assign in_oor_c = 1'b0;
  end

  assign sel_oor_c = (state_q == ST_IDLE) ? in_oor_c : oor_q;
`endif

  always_comb begin
    if (state_q == ST_IDLE) begin
      sel_idx_c   = in_idx_c;
      sel_wdata_c = bus.cpu_datamem_wdata;
      sel_bsel_c  = bus.cpu_datamem_bytesel;
    end else begin
      sel_idx_c   = widx_q;
      sel_wdata_c = wdata_q;
      sel_bsel_c  = bsel_q;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    bsel_d      = bsel_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    enter_ack_c = 1'b0;
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
    oor_d       = oor_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_datamem_req) begin
          widx_d  = in_idx_c;
          wdata_d = bus.cpu_datamem_wdata;
          bsel_d  = bus.cpu_datamem_bytesel;
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
          oor_d   = in_oor_c;
`endif
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            wcnt_d  = CW'(WAIT_STATES - 1);
          end else begin
            state_d     = ST_ACK;
            enter_ack_c = 1'b1;
          end
        end
      end

      // req and the bus payload are not looked at while waiting.
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          state_d     = ST_ACK;
          enter_ack_c = 1'b1;
        end else begin
          wcnt_d = wcnt_q - CW'(1);
        end
      end

      // req is still high here; it belongs to the transaction being acked.
      ST_ACK: begin
        state_d = ST_IDLE;
        ack_d   = 1'b1;
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
        err_d   = oor_q;
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reads load rdata on the edge entering ACK; writes leave it alone.
    if (enter_ack_c && (sel_bsel_c == '0)) begin
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
      rdata_d = sel_oor_c ? DW'(32'hDEAD_BEEF) : mem_q[sel_idx_c];
`else
      rdata_d = mem_q[sel_idx_c];
`endif
    end
  end

  // Write strobe; a reset on the commit edge drops the write.
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
  assign we_c = enter_ack_c && (sel_bsel_c != '0) && !sel_oor_c && !rst;
`else
  assign we_c = enter_ack_c && (sel_bsel_c != '0) && !rst;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      bsel_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      bsel_q  <= bsel_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
      oor_q   <= oor_d;
      err_q   <= err_d;
`endif
    end
  end

  // RAM array, byte-lane writes, no reset.
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int k = 0; k < int'(NB); k++) begin
        if (sel_bsel_c[k]) begin
          mem_q[sel_idx_c][8*k +: 8] <= sel_wdata_c[8*k +: 8];
        end
      end
    end
  end

  assign bus.datamem_cpu_rdata = rdata_q;
  assign bus.datamem_cpu_ack   = ack_q;
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
  assign bus.datamem_cpu_err   = err_q;
`endif

endmodule : nanorv32_datamem_resp

// File: tb/tb_nanorv32_datamem_resp.sv
// Scoreboard bench for nanorv32_datamem_resp: three responders with
// WAIT_STATES 0, 3 and 4 share clk/rst; directed transactions push the
// expected ack cycle / rdata / err into a per-instance queue and a monitor
// per instance pops and compares on every ack.
module tb_nanorv32_datamem_resp;

  localparam int N = 3;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  exp_t        sbq [N][$];

  logic        req_s   [N];
  logic [31:0] addr_s  [N];
  logic [31:0] wdata_s [N];
  logic [3:0]  bsel_s  [N];
  logic [31:0] rdata_s [N];
  logic        ack_s   [N];
  logic        err_s   [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned ws_of(input int id);
    return (id == 0) ? 0 : ((id == 1) ? 3 : 4);
  endfunction

  task automatic check32(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%08h required=%08h", name, id, cyc, act, exp);
    end
  endtask

  task automatic check1(input string name, input int id, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%b required=%b", name, id, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    nanorv32_datamem_resp_if #(.ADDR_MSB(31), .DATA_MSB(31)) bus ();

    assign bus.cpu_datamem_addr    = addr_s[g];
    assign bus.cpu_datamem_wdata   = wdata_s[g];
    assign bus.cpu_datamem_bytesel = bsel_s[g];
    assign bus.cpu_datamem_req     = req_s[g];
    assign rdata_s[g]              = bus.datamem_cpu_rdata;
    assign ack_s[g]                = bus.datamem_cpu_ack;
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
    assign err_s[g]                = bus.datamem_cpu_err;
`else
    assign err_s[g]                = 1'b0;
`endif

    nanorv32_datamem_resp #(
      .DEPTH      (1024),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 4)),
      .ADDR_MSB   (31),
      .DATA_MSB   (31)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );

    logic prev_ack = 1'b0;
    exp_t e;

    // Monitor: every ack must be expected, on time, with the right data.
    always @(negedge clk) begin
      if (rst) begin
        prev_ack = 1'b0;
      end else begin
        if (ack_s[g]) begin
          check1("ack_not_consecutive", g, prev_ack, 1'b0);
          if (sbq[g].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack dut%0d cyc=%0d actual=ack required=no_ack", g, cyc);
          end else begin
            e = sbq[g].pop_front();
            check32("ack_cycle", g, cyc, e.cyc);
            if (e.chk_rdata) check32("rdata", g, rdata_s[g], e.rdata);
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
            check1("err", g, err_s[g], e.err);
`endif
          end
        end
        prev_ack = ack_s[g];
      end
    end
  end

  // One handshake; optionally disturbs the bus one cycle after acceptance.
  task automatic txn(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] bsel, input logic [31:0] exp_rd, input bit chk,
                     input bit exp_err, input bit chg, input logic [31:0] new_addr);
    exp_t e;
    bit   done;
    @(negedge clk);
    addr_s[id]  = addr;
    wdata_s[id] = wdata;
    bsel_s[id]  = bsel;
    req_s[id]   = 1'b1;
    @(posedge clk);
    #1;
    e.cyc       = cyc + 1 + ws_of(id);
    e.rdata     = exp_rd;
    e.chk_rdata = chk;
    e.err       = exp_err;
    sbq[id].push_back(e);
    if (chg) begin
      @(posedge clk);
      #1;
      addr_s[id]  = new_addr;
      wdata_s[id] = ~wdata;
      bsel_s[id]  = 4'hF;
    end
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (ack_s[id]) done = 1'b1;
    end
    req_s[id]  = 1'b0;
    bsel_s[id] = 4'h0;
    check1("ack_seen", id, done, 1'b1);
  endtask

  task automatic wr(input int id, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] bsel);
    txn(id, addr, data, bsel, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input int id, input logic [31:0] addr, input logic [31:0] exp_rd);
    txn(id, addr, 32'h0, 4'h0, exp_rd, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp  [3];
    exp_t        e;

    for (int i = 0; i < N; i++) begin
      req_s[i]   = 1'b0;
      addr_s[i]  = 32'h0;
      wdata_s[i] = 32'h0;
      bsel_s[i]  = 4'h0;
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check32("reset_rdata", i, rdata_s[i], 32'h0);
      check1("reset_ack", i, ack_s[i], 1'b0);
    end
    rst = 1'b0;

    // WAIT_STATES=0: full word, lanes, misaligned, top word.
    wr(0, 32'h10, 32'h1122_3344, 4'hF);
    rd(0, 32'h10, 32'h1122_3344);
    txn(0, 32'h10, 32'hAABB_CCDD, 4'b0101, 32'h1122_3344, 1'b1, 1'b0, 1'b0, 32'h0);
    rd(0, 32'h10, 32'h11BB_33DD);
    wr(0, 32'h13, 32'hEE00_0000, 4'b1000);
    rd(0, 32'h11, 32'hEEBB_33DD);
    wr(0, 32'hFFC, 32'h7E57_AB1E, 4'hF);
    rd(0, 32'hFFC, 32'h7E57_AB1E);
    wr(0, 32'h100, 32'h0101_0101, 4'hF);
    wr(0, 32'h104, 32'h0202_0202, 4'hF);

    // Back-to-back reads with req held: accepts every other edge.
    b2b_addr[0] = 32'h10;  b2b_exp[0] = 32'hEEBB_33DD;
    b2b_addr[1] = 32'h100; b2b_exp[1] = 32'h0101_0101;
    b2b_addr[2] = 32'h104; b2b_exp[2] = 32'h0202_0202;
    @(negedge clk);
    addr_s[0] = b2b_addr[0];
    bsel_s[0] = 4'h0;
    req_s[0]  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      e.cyc       = cyc + 1;
      e.rdata     = b2b_exp[k];
      e.chk_rdata = 1'b1;
      e.err       = 1'b0;
      sbq[0].push_back(e);
      if (k < 2) addr_s[0] = b2b_addr[k+1];
      else       req_s[0]  = 1'b0;
      @(posedge clk);
    end
    repeat (4) @(negedge clk);

`ifdef NANORV32_DATAMEM_RESP_ERR_EN
    wr(0, 32'h0, 32'h1357_9BDF, 4'hF);
    txn(0, 32'h1000, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    txn(0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h0);
    rd(0, 32'h0, 32'h1357_9BDF);
`else
    wr(0, 32'h1000, 32'h0BAD_F00D, 4'hF);
    rd(0, 32'h0, 32'h0BAD_F00D);
`endif

    // WAIT_STATES=3: payload changes after acceptance are ignored.
    wr(1, 32'h20, 32'h5566_7788, 4'hF);
    wr(1, 32'h30, 32'h99AA_BBCC, 4'hF);
    txn(1, 32'h30, 32'h0, 4'h0, 32'h99AA_BBCC, 1'b1, 1'b0, 1'b1, 32'h20);
    rd(1, 32'h20, 32'h5566_7788);

    // WAIT_STATES=4: reset while a write is pending drops it.
    wr(2, 32'h40, 32'h1234_5678, 4'hF);
    rd(2, 32'h40, 32'h1234_5678);
    @(negedge clk);
    addr_s[2]  = 32'h40;
    wdata_s[2] = 32'hCAFE_F00D;
    bsel_s[2]  = 4'hF;
    req_s[2]   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    req_s[2]  = 1'b0;
    bsel_s[2] = 4'h0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check32("post_reset_rdata", 2, rdata_s[2], 32'h0);
    check1("post_reset_ack", 2, ack_s[2], 1'b0);
    repeat (10) @(negedge clk);
    rd(2, 32'h40, 32'h1234_5678);

    repeat (8) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check32("scoreboard_drained", i, 32'(sbq[i].size()), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nanorv32_datamem_resp
